// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port byte memory between instruction fetch
// and the data-side load/store, registering returned data and bounding fetch starvation.
// Optional build macro: ARB_ALIGN_CHECK_EN enables misaligned data access detection
// (the access is granted but suppressed at the memory and reported as d_fault).
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        stall,
  // data side
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [2:0]  d_fun3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  // memory port
  output logic        m_MemRead,
  output logic        m_MemWrite,
  output logic [2:0]  m_fun3,
  output logic [5:0]  m_addr,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out
);

  typedef enum logic [1:0] {
    Idle,
    GntData,
    GntFetch
  } grant_e;

  grant_e           grant;
  logic [CNT_W-1:0] starve_cnt;
  logic             data_req;
  logic             at_limit;
  logic             is_load;
  logic             misaligned;

  // Address bits beyond the memory's reach wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_pc[31:8], if_pc[1:0], d_addr[31:6]};

  assign data_req = d_rd | d_wr;
  assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // d_wr wins if both strobes are (illegally) raised together.
  assign is_load  = d_rd & ~d_wr;

`ifdef ARB_ALIGN_CHECK_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    case (d_fun3)
      3'b001, 3'b101: misaligned = d_addr[0];
      3'b010:         misaligned = |d_addr[1:0];
      default:        misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Data wins unless fetch has been starved STARVE_LIMIT times in a row.
  always_comb begin
    if (data_req && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      grant = GntData;
    end else if (if_req) begin
      grant = GntFetch;
    end else begin
      grant = Idle;
    end
  end

  // Drive the memory port and handshakes from the current grant.
  always_comb begin
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    m_MemRead  = 1'b0;
    m_MemWrite = 1'b0;
    m_fun3     = 3'b000;
    m_addr     = 6'd0;
    m_data_in  = 32'd0;
    unique case (grant)
      GntFetch: begin
        // Fetch is encoded as both strobes low with a word index.
        if_ready = 1'b1;
        m_addr   = if_pc[7:2];
        m_fun3   = 3'b010;
      end
      GntData: begin
        d_ready    = 1'b1;
        m_MemRead  = is_load & ~misaligned;
        m_MemWrite = d_wr & ~misaligned;
        m_addr     = d_addr[5:0];
        m_fun3     = d_fun3;
        m_data_in  = d_wdata;
      end
      default: ;
    endcase
    // No write may land while reset is asserted, even mid-cycle.
    if (rst) begin
      m_MemRead  = 1'b0;
      m_MemWrite = 1'b0;
    end
  end

  assign stall = if_req & ~if_ready;

  // Register returned data and track consecutive data wins over a waiting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'd0;
      d_fault    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_valid <= (grant == GntFetch);
      if (grant == GntFetch) begin
        if_instr <= m_data_out;
      end
      d_rvalid <= (grant == GntData);
      d_fault  <= (grant == GntData) & misaligned;
      if (grant == GntData) begin
        d_rdata <= (is_load && !misaligned) ? m_data_out : 32'd0;
      end
      if ((grant == GntFetch) || !if_req) begin
        starve_cnt <= '0;
      end else if ((grant == GntData) && !at_limit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: bench-owned byte memory on the memory port, a
// behavioural model of arbitration and data return, directed cases and random traffic.
module tb_imem_dmem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ready, if_valid, stall;
  logic [31:0] if_instr;
  logic        d_rd, d_wr;
  logic [2:0]  d_fun3;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid, d_fault;
  logic [31:0] d_rdata;
  logic        m_MemRead, m_MemWrite;
  logic [2:0]  m_fun3;
  logic [5:0]  m_addr;
  logic [31:0] m_data_in, m_data_out;

  imem_dmem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_pc     (if_pc),
    .if_ready  (if_ready),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .stall     (stall),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_fun3    (d_fun3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_fault   (d_fault),
    .m_MemRead (m_MemRead),
    .m_MemWrite(m_MemWrite),
    .m_fun3    (m_fun3),
    .m_addr    (m_addr),
    .m_data_in (m_data_in),
    .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  // mem is the memory the DUT talks to; ref_mem is what the model says it should hold.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int errors = 0;
  int checks = 0;

  // Model state.
  int          cnt_m = 0;
  bit          exp_if_valid, exp_d_rvalid, exp_d_fault;
  logic [31:0] exp_if_instr, exp_d_rdata;
  bit          if_acc = 1'b0, d_acc = 1'b0;

  // Combinational memory read: both strobes low means word-indexed fetch.
  always_comb begin : mem_read
    logic [7:0]  b;
    logic [31:0] w;
    b = (!m_MemRead && !m_MemWrite) ? {m_addr, 2'b00} : {2'b00, m_addr};
    w = {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    m_data_out = w;
    if (m_MemRead) begin
      case (m_fun3)
        3'b000:  m_data_out = {{24{w[7]}}, w[7:0]};
        3'b001:  m_data_out = {{16{w[15]}}, w[15:0]};
        3'b100:  m_data_out = {24'd0, w[7:0]};
        3'b101:  m_data_out = {16'd0, w[15:0]};
        default: m_data_out = w;
      endcase
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(logic [7:0] b);
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(logic [5:0] a, logic [2:0] f);
    logic [31:0] w;
    w = ref_word({2'b00, a});
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit misaligned(logic [2:0] f, logic [1:0] a);
`ifdef ARB_ALIGN_CHECK_EN
    if (f == 3'b001 || f == 3'b101) return a[0];
    if (f == 3'b010) return a != 2'b00;
    return 1'b0;
`else
    return (f === 3'bxxx) && (a === 2'bxx);
`endif
  endfunction

  task automatic mem_put(bit to_ref, logic [7:0] b, logic [2:0] f, logic [31:0] d);
    int n;
    n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      logic [7:0] idx;
      idx = b + 8'(i);
      if (to_ref) ref_mem[idx] = d[8*i +: 8];
      else mem[idx] = d[8*i +: 8];
    end
  endtask

  // One clock cycle with inputs already driven: check combinational outputs against
  // the model, let the memory and DUT clock, then check the registered outputs.
  task automatic step();
    int          g;
    bit          mis, ld;
    logic        st_we;
    logic [5:0]  st_a;
    logic [2:0]  st_f;
    logic [31:0] st_d;
    #1;
    if ((d_rd || d_wr) && cnt_m < STARVE_LIMIT) g = 1;
    else if (if_req) g = 2;
    else g = 0;
    mis = misaligned(d_fun3, d_addr[1:0]);
    ld  = d_rd && !d_wr;
    chk("if_ready", {31'd0, if_ready}, {31'd0, g == 2});
    chk("d_ready", {31'd0, d_ready}, {31'd0, g == 1});
    chk("stall", {31'd0, stall}, {31'd0, if_req && g != 2});
    chk("m_MemRead", {31'd0, m_MemRead}, {31'd0, g == 1 && ld && !mis});
    chk("m_MemWrite", {31'd0, m_MemWrite}, {31'd0, g == 1 && d_wr && !mis});
    chk("m_addr", {26'd0, m_addr}, (g == 2) ? {26'd0, if_pc[7:2]} :
                                   (g == 1) ? {26'd0, d_addr[5:0]} : 32'd0);
    chk("m_fun3", {29'd0, m_fun3}, (g == 2) ? 32'd2 : (g == 1) ? {29'd0, d_fun3} : 32'd0);
    if (g == 1) chk("m_data_in", m_data_in, d_wdata);
    exp_if_valid = (g == 2);
    if (g == 2) exp_if_instr = ref_word({if_pc[7:2], 2'b00});
    exp_d_rvalid = (g == 1);
    exp_d_fault  = (g == 1) && mis;
    if (g == 1) exp_d_rdata = (ld && !mis) ? ref_load(d_addr[5:0], d_fun3) : 32'd0;
    if (g == 1 && d_wr && !mis) mem_put(1'b1, {2'b00, d_addr[5:0]}, d_fun3, d_wdata);
    if (g == 2 || !if_req) cnt_m = 0;
    else if (g == 1 && cnt_m < STARVE_LIMIT) cnt_m++;
    if_acc = (g == 2);
    d_acc  = (g == 1);
    st_we = m_MemWrite;
    st_a  = m_addr;
    st_f  = m_fun3;
    st_d  = m_data_in;
    @(posedge clk);
    #1;
    if (st_we) mem_put(1'b0, {2'b00, st_a}, st_f, st_d);
    chk("if_valid", {31'd0, if_valid}, {31'd0, exp_if_valid});
    chk("if_instr", if_instr, exp_if_instr);
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d_rvalid});
    chk("d_fault", {31'd0, d_fault}, {31'd0, exp_d_fault});
    if (exp_d_rvalid) chk("d_rdata", d_rdata, exp_d_rdata);
    @(negedge clk);
  endtask

  task automatic drive(bit req, logic [31:0] pc, bit rd, bit wr, logic [2:0] f,
                       logic [31:0] a, logic [31:0] wd);
    if_req  = req;
    if_pc   = pc;
    d_rd    = rd;
    d_wr    = wr;
    d_fun3  = f;
    d_addr  = a;
    d_wdata = wd;
  endtask

  initial begin
    logic [2:0] fsel [5];
    logic [7:0] old_b [4];
    logic       we;
    fsel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset with a load pending: strobes must stay low while rst is high.
    rst = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_MemRead", {31'd0, m_MemRead}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_d_fault", {31'd0, d_fault}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    exp_if_instr = 32'd0;

    // Two back-to-back fetches.
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0000_0083;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h0000_0073;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
    drive(1'b1, 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1 chk("fetch0_ready", {31'd0, if_ready}, 32'd1);
    step();
    chk("fetch0_instr", if_instr, 32'h0000_0083);
    if_pc = 32'd4;
    #1 chk("fetch1_ready", {31'd0, if_ready}, 32'd1);
    step();
    chk("fetch1_valid", {31'd0, if_valid}, 32'd1);
    chk("fetch1_instr", if_instr, 32'h0000_0073);

    // Load byte wins over a simultaneous fetch.
    mem[0] = 8'd2; mem[1] = 8'd3; mem[2] = 8'd5;
    for (int i = 0; i < 3; i++) ref_mem[i] = mem[i];
    drive(1'b1, 32'd0, 1'b1, 1'b0, 3'b000, 32'd1, 32'd0);
    #1;
    chk("lb_d_ready", {31'd0, d_ready}, 32'd1);
    chk("lb_stall", {31'd0, stall}, 32'd1);
    chk("lb_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    chk("lb_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("lb_rdata", d_rdata, 32'h0000_0003);

    // Store word then read it back as a word and as a signed byte.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF);
    step();
    chk("sw_rdata_zero", d_rdata, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 3'b010, 32'd8, 32'd0);
    step();
    chk("lw_rdata", d_rdata, 32'hDEAD_BEEF);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 3'b000, 32'd11, 32'd0);
    step();
    chk("lb11_rdata", d_rdata, 32'hFFFF_FFDE);

    // Sustained loads against a waiting fetch: fetch forced through every fifth cycle.
    drive(1'b1, 32'd0, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("starve_if_ready", {31'd0, if_ready}, {31'd0, (i % 5) == 0});
      chk("starve_stall", {31'd0, stall}, {31'd0, (i % 5) != 0});
      step();
    end

    // Illegal rd+wr together behaves as a store.
    drive(1'b0, 32'd0, 1'b1, 1'b1, 3'b000, 32'd30, 32'h0000_005A);
    step();
    chk("rdwr_rdata", d_rdata, 32'd0);

`ifdef ARB_ALIGN_CHECK_EN
    // Misaligned word store: granted, suppressed, reported as a fault.
    for (int i = 0; i < 4; i++) old_b[i] = mem[2 + i];
    drive(1'b0, 32'd0, 1'b0, 1'b1, 3'b010, 32'd2, 32'h1234_5678);
    #1;
    chk("mis_d_ready", {31'd0, d_ready}, 32'd1);
    chk("mis_m_MemWrite", {31'd0, m_MemWrite}, 32'd0);
    step();
    chk("mis_fault", {31'd0, d_fault}, 32'd1);
    chk("mis_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("mis_rdata", d_rdata, 32'd0);
    for (int i = 0; i < 4; i++) chk("mis_mem_kept", {24'd0, mem[2 + i]}, {24'd0, old_b[i]});
`endif

    // Reset asserted mid-cycle during a granted byte store, with the counter at 3.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    step();
    drive(1'b1, 32'd0, 1'b0, 1'b1, 3'b000, 32'd16, 32'h0000_0011);
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 32'd0, 1'b0, 1'b1, 3'b000, 32'd20, 32'h0000_00AB);
    old_b[0] = mem[20];
    #1 chk("rstmid_we_before", {31'd0, m_MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_we", {31'd0, m_MemWrite}, 32'd0);
    chk("rstmid_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rstmid_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    we = m_MemWrite;
    @(posedge clk);
    #1;
    if (we) mem_put(1'b0, 8'd20, 3'b000, 32'h0000_00AB);
    chk("rstmid_mem_kept", {24'd0, mem[20]}, {24'd0, old_b[0]});
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_cnt", {29'd0, dut.starve_cnt}, 32'd0);
    cnt_m = 0;
    exp_if_instr = 32'd0;
    // Counter restarts from zero: four data wins before fetch is forced.
    drive(1'b1, 32'd4, 1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      #1 chk("post_rst_if_ready", {31'd0, if_ready}, {31'd0, i == 5});
      step();
    end

    // Random traffic; each requester holds its request until accepted.
    for (int n = 0; n < 1500; n++) begin
      if (!(if_req && !if_acc)) begin
        if_req = ($urandom_range(0, 9) < 7);
        if_pc  = $urandom;
      end
      if (!((d_rd || d_wr) && !d_acc)) begin
        int r;
        logic [2:0] f;
        r    = $urandom_range(0, 19);
        d_rd = (r < 8) || (r == 19);
        d_wr = (r >= 8 && r < 14) || (r == 19);
        f    = fsel[$urandom_range(0, 4)];
        if (d_wr) f[2] = 1'b0;
        d_fun3  = f;
        d_addr  = $urandom;
        if ($urandom_range(0, 1) == 0) d_addr[1:0] = 2'b00;
        d_wdata = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Sits directly upstream of the unified single-port byte memory.
- Arbitrates between the IF-stage instruction fetch and the MEM-stage load/store for that one port.
- Translates requests into the memory's control encoding: fetch is signalled by both MemRead and MemWrite low, with a word index; data accesses use a byte address.
- Registers the returned data, raises a stall to the front end when fetch loses arbitration, and bounds fetch starvation.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data wins while fetch is waiting; the next cycle is forced to fetch.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_pc  in  32  fetch byte PC
- if_ready  out  1  fetch accepted this cycle (combinational)
- if_valid  out  1  if_instr valid (registered, cycle after accept)
- if_instr  out  32  fetched instruction
- stall  out  1  if_req high and fetch not granted this cycle
- d_rd  in  1  load request
- d_wr  in  1  store request
- d_fun3  in  3  RISC-V funct3 size/sign
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  access complete (registered pulse; loads and stores)
- d_rdata  out  32  load data, 0 for stores and faults
- d_fault  out  1  misaligned access, pulses with d_rvalid
- m_MemRead  out  1  to memory
- m_MemWrite  out  1  to memory
- m_fun3  out  3  to memory
- m_addr  out  6  to memory: word index for fetch, byte address for data
- m_data_in  out  32  to memory
- m_data_out  in  32  from memory (combinational read)

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values: if_valid=0, d_rvalid=0, d_fault=0, if_instr=0, d_rdata=0, starvation counter=0.
- While rst is high, m_MemRead and m_MemWrite are forced to 0, so no write can land.
- Arbitration is combinational each cycle. The grant is held in a state code: IDLE, GNT_DATA or GNT_FETCH.
  - GNT_DATA when (d_rd|d_wr) and the counter is below STARVE_LIMIT.
  - GNT_FETCH when if_req and (no data request, or counter == STARVE_LIMIT).
  - IDLE otherwise.
- d_rd and d_wr asserted together is illegal; d_wr takes precedence.
- GNT_FETCH drives the memory port as: m_MemRead=0, m_MemWrite=0, m_addr=if_pc[7:2], m_fun3=3'b010. if_ready=1.
- GNT_DATA drives the memory port as: m_MemRead=d_rd&~d_wr, m_MemWrite=d_wr, m_addr=d_addr[5:0], m_fun3=d_fun3, m_data_in=d_wdata. d_ready=1.
- IDLE: all strobes 0, m_addr=0.
- At each posedge:
  - A granted fetch sets if_instr=m_data_out and if_valid=1. Otherwise if_valid=0 and if_instr holds.
  - A granted data access sets d_rvalid=1. d_rdata=m_data_out for a load, 0 for a store.
- Latency: exactly 1 cycle from accept to valid, sustainable at 1 access per cycle per requester.
- Starvation counter:
  - Increments on a GNT_DATA cycle with if_req high.
  - Clears on a GNT_FETCH cycle or when if_req is low.
  - Saturates at STARVE_LIMIT.
- stall = if_req & ~if_ready.
- Upper address bits are ignored: if_pc[31:8] and d_addr[31:6] wrap silently.

Optional Feature:
- Macro ARB_ALIGN_CHECK_EN.
- When defined, a misaligned data request is detected:
  - Halfword (fun3 001/101) with d_addr[0]=1.
  - Word (fun3 010) with d_addr[1:0]!=0.
- A misaligned request is still granted (d_ready=1) but m_MemRead=m_MemWrite=0. The next cycle gives d_rvalid=1, d_fault=1, d_rdata=0.
- When not defined, there is no detection: the access is forwarded unchanged and d_fault is tied 0.

Test Plan:
- Memory word 0=0x00000083 and word 1=0x00000073; if_req with if_pc=0 then 4 -> if_ready=1 both cycles; if_valid with if_instr 0x00000083 then 0x00000073 on consecutive cycles.
- mem[0..2]=2,3,5; d_rd with fun3=000 and d_addr=1, simultaneous with if_req -> d_ready=1, stall=1, if_ready=0; next cycle d_rvalid=1, d_rdata=0x00000003.
- d_wr with fun3=010, d_addr=8, d_wdata=0xDEADBEEF, then d_rd with fun3=010, d_addr=8 -> d_rdata=0xDEADBEEF; then d_rd with fun3=000, d_addr=11 -> 0xFFFFFFDE.
- d_rd held for 10 cycles with if_req high -> exactly one if_ready in every 5 cycles (cycles 5 and 10); stall high otherwise.
- ARB_ALIGN_CHECK_EN defined, d_wr with fun3=010 and d_addr=2 -> m_MemWrite=0, then d_fault=1 and d_rvalid=1; memory bytes 2..5 unchanged.
- rst pulsed mid-cycle while a d_wr grant is in progress -> m_MemWrite drops immediately, if_valid and d_rvalid go to 0, the target byte is unchanged, and the counter equals 0 after release.
